// File: rtl/parallel_to_serial_if.sv
// Load handshake and serial link bundle for parallel_to_serial.
// master: word producer / link observer side; slave: the serializer.
`timescale 1ns/1ps
interface parallel_to_serial_if #(
  parameter int unsigned Width = 16
);
  logic [Width-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output load_data, load_valid,
    input  load_ready, sout, sout_valid, done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, sout, sout_valid, done
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out MSB first, one bit per clock, with a frame
// qualifier and a one-cycle end-of-word pulse.
// Optional feature: define P2S_BACK_TO_BACK_EN to allow a new word to be
// accepted while the last bit of the current word is on sout (gapless).
`timescale 1ns/1ps
module parallel_to_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  parallel_to_serial_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             load_ready;
  logic             accept;

  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

  // Ready is a pure function of state so the producer sees it before the edge.
  always_comb begin
`ifdef P2S_BACK_TO_BACK_EN
    load_ready = (state_q == StIdle) || last_bit;
`else
    load_ready = (state_q == StIdle);
`endif
  end

  assign accept = bus.load_valid && load_ready;

  // Next-state: load on accept, otherwise shift until the last bit, then idle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = bus.load_data;
          sout_d  = bus.load_data[WIDTH-1];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
          done_d = 1'b1;
          if (accept) begin
            // Only reachable with back-to-back enabled: MSB follows the LSB directly.
            shift_d = bus.load_data;
            sout_d  = bus.load_data[WIDTH-1];
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            shift_d = '0;
            sout_d  = 1'b0;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          sout_d  = shift_q[WIDTH-2];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: directed steps plus random traffic, checked
// against a queue-of-bits reference model and a 16-stage shift-in receiver.
`timescale 1ns/1ps
module tb_parallel_to_serial;

  localparam int unsigned W = 16;
`ifdef P2S_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk;
  logic rst_ni;
  parallel_to_serial_if #(.Width(W)) bus ();

  parallel_to_serial #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model: bits still to appear on sout (front = current cycle),
  // words in flight, and the expected done for the current cycle.
  logic         exp_bits[$];
  logic [W-1:0] words[$];
  logic         exp_done = 1'b0;
  logic [W-1:0] rx = '0;
  logic         acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_sout();
    return (exp_bits.size() != 0) ? exp_bits[0] : 1'b0;
  endfunction

  function automatic logic exp_valid();
    return exp_bits.size() != 0;
  endfunction

  task automatic model_clear();
    exp_bits.delete();
    words.delete();
    exp_done = 1'b0;
    rx = '0;
  endtask

  // One clock cycle: check outputs at the negedge, drive inputs, advance model.
  task automatic step(input logic v, input logic [W-1:0] d);
    logic s_sout, s_valid, ready_m;
    logic [W-1:0] w_done;
    @(negedge clk);
    chk("sout", 32'(bus.sout), 32'(exp_sout()));
    chk("sout_valid", 32'(bus.sout_valid), 32'(exp_valid()));
    chk("done", 32'(bus.done), 32'(exp_done));
    s_sout  = bus.sout;
    s_valid = bus.sout_valid;
    bus.load_valid = v;
    bus.load_data  = d;
    ready_m = (exp_bits.size() == 0) || (B2B && exp_bits.size() == 1);
    #1;
    chk("load_ready", 32'(bus.load_ready), 32'(ready_m));
    acc = v && ready_m && rst_ni;
    @(posedge clk);
    if (!rst_ni) begin
      model_clear();
      return;
    end
    if (s_valid) rx = {rx[W-2:0], s_sout};
    exp_done = 1'b0;
    if (exp_bits.size() != 0) begin
      void'(exp_bits.pop_front());
      if (exp_bits.size() == 0) begin
        exp_done = 1'b1;
        w_done = words.pop_front();
        chk("rx_word", 32'(rx), 32'(w_done));
      end
    end
    if (acc) begin
      for (int i = W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
      words.push_back(d);
    end
  endtask

  // Offer a word until accepted, bounded.
  task automatic send(input logic [W-1:0] d);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      step(1'b1, d);
      got = acc;
    end
    chk("accepted", 32'(got), 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    #1;
    chk("rst_sout", 32'(bus.sout), 32'd0);
    chk("rst_valid", 32'(bus.sout_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // Reset held for three cycles, then idle.
    repeat (3) step(1'b0, '0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (20) step(1'b0, '0);

    // Single word, then drain.
    send(16'hA5C3);
    repeat (W + 2) step(1'b0, '0);

    // Stall: a second offer during SHIFT must be ignored.
    send(16'h3C5A);
    repeat (6) step(1'b1, 16'h1234);
    repeat (W) step(1'b0, '0);

    // Back-to-back with load_valid held.
    send(16'hFFFF);
    send(16'h0001);
    repeat (W + 3) step(1'b0, '0);

    // Reset mid-word after eight bits have gone out.
    send(16'hF0F0);
    repeat (8) step(1'b0, '0);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("abort_sout", 32'(bus.sout), 32'd0);
    chk("abort_valid", 32'(bus.sout_valid), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    model_clear();
    repeat (2) step(1'b0, '0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) step(1'b0, '0);
    send(16'h8001);
    repeat (W + 2) step(1'b0, '0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom));
    end
    bus.load_valid = 1'b0;
    repeat (W + 2) step(1'b0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side counterpart to the team's 16-stage serial-to-parallel capture register. Accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock, MSB first, with a frame-valid qualifier and an end-of-word pulse. The bit order is chosen so that a 16-stage shift-in receiver on the same clock holds the word exactly after the 16th bit: its last stage equals word bit 15 and its first stage equals bit 0. Sits between a word-producing datapath and a single-wire serial link.

## Interface
- WIDTH, 16: word length in bits; legal range ≥ 2.
- clk  in  1: single clock; all state changes on rising edge.
- reset  in  1: asynchronous, active-low; low forces the reset state immediately.
- load_data  in  WIDTH: word to transmit; sampled only on an accepted load.
- load_valid  in  1: producer offers load_data this cycle.
- load_ready  out  1: block can accept a word this cycle; combinational from state.
- sout  out  1: serial data, registered.
- sout_valid  out  1: sout carries a word bit this cycle, registered.
- done  out  1: one-cycle pulse after the last bit of a word has been shifted out, registered.

## Operation
- Reset values: sout=0, sout_valid=0, done=0, state=IDLE, bit counter=0, shift register=0. load_ready reads 1 once reset is released.
- Internal state: WIDTH-bit shift register, bit counter of $clog2(WIDTH) bits, and a 2-state FSM with states IDLE and SHIFT.
- Accept: a word is accepted on a rising edge where load_valid=1 and load_ready=1.
- IDLE:
  - load_ready=1, sout=0, sout_valid=0.
  - On accept: capture load_data, set sout=load_data[WIDTH-1], sout_valid=1, counter=0, go to SHIFT.
- SHIFT:
  - On each edge: counter+1, shift left, sout=next-lower bit.
  - While counter==WIDTH-1 (the last bit is on sout), the next edge ends the word: done=1 for one cycle.
  - If no new word is accepted at that edge: go to IDLE, sout=0, sout_valid=0.
  - Back-to-back accept: see Configuration.
- load_ready=0 in SHIFT except as enabled under Configuration. load_valid while load_ready=0 is ignored; the producer must hold the word.
- Changes on load_data after accept do not affect the word in flight.
- Reset asserted mid-word: asynchronously abort. Outputs go to reset values and the partial word is discarded; no done pulse.

## Timing
- Accept at edge k: sout carries bit WIDTH-1-j in the cycle following edge k+j, for j=0..WIDTH-1. sout_valid=1 in those same WIDTH cycles.
- A receiver sampling sout at edges k+1..k+WIDTH holds the complete word after edge k+WIDTH.
- done=1 in the cycle following edge k+WIDTH.
- Load-to-first-bit latency: 0 cycles after the accepting edge. Occupancy: WIDTH cycles per word.

## Configuration
- P2S_BACK_TO_BACK_EN defined:
  - load_ready=1 also in SHIFT while counter==WIDTH-1.
  - An accept at edge k+WIDTH loads the new word and drives its MSB on sout. sout_valid stays 1, state stays SHIFT, counter resets to 0, and done still pulses for the finished word.
  - Gapless streaming: one word every WIDTH cycles.
- P2S_BACK_TO_BACK_EN undefined:
  - load_ready=0 throughout SHIFT. The FSM always returns to IDLE after the last bit.
  - The earliest next accept is edge k+WIDTH+1, so there is at least one idle cycle between words with sout_valid=0.

## Test plan
- Reset then idle: hold reset low 3 cycles, release, load_valid=0 for 20 cycles -> sout=0, sout_valid=0, done=0, load_ready=1 throughout.
- Single word 0xA5C3 (WIDTH=16): accept at edge k -> sout sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over 16 cycles with sout_valid=1. done=1 for exactly one cycle after edge k+16. A model 16-stage shift-in receiver then reads 0xA5C3.
- Stall: load_valid=1 with 0x1234 while SHIFT (not last bit) -> load_ready=0; the word is not taken, and the in-flight word's bits are unchanged.
- Back-to-back, 0xFFFF then 0x0001 with load_valid held:
  - Macro defined -> 32 contiguous sout_valid cycles; done pulses at edges k+16 and k+32.
  - Macro undefined -> exactly one sout_valid=0 gap cycle between the words.
- Reset mid-word: assert reset low after bit 7 of 0xF0F0 -> sout, sout_valid, done go 0 without waiting for a clock edge. No done pulse. After release, load_ready=1 and a fresh word 0x8001 transmits correctly.
